// File: rtl/decoder_stage_controller_pkg.sv
// Shared parameters for the Union-Find decoder stage sequencing.
// Holds the stage bus width, the fixed stage encodings broadcast to every
// processing unit, the controller FSM/phase enums and the helper that sizes
// a context index.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS         = 3'd7;

  // The FSM state doubles as the registered stage broadcast, so the state
  // encodings are exactly the stage encodings.
  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE         = STAGE_IDLE,
    ST_MEAS_LOAD    = STAGE_MEASUREMENT_LOADING,
    ST_GROW         = STAGE_GROW,
    ST_MERGE        = STAGE_MERGE,
    ST_PEELING      = STAGE_PEELING,
    ST_RESULT_VALID = STAGE_RESULT_VALID,
    ST_WRITE_TO_MEM = STAGE_WRITE_TO_MEM,
    ST_RESET_ROOTS  = STAGE_RESET_ROOTS
  } stage_e;

  // WRITE_TO_MEM is shared by all three phases; the phase decides where it
  // goes next.
  typedef enum logic [1:0] {
    PH_LOAD  = 2'd0,
    PH_SOLVE = 2'd1,
    PH_PEEL  = 2'd2
  } phase_e;

  function automatic int ctxIdxWidth(input int numContexts);
    return (numContexts > 1) ? $clog2(numContexts) : 1;
  endfunction

endpackage

// File: rtl/merge_quiet_counter.sv
// Quiet-cycle detector for the MERGE stage.
// Counts consecutive cycles with i_busy low while i_active is high. The
// first two cycles of every activation are blanked because the PEs only see
// the new stage one cycle after the controller registers it, and their busy
// flag is itself registered.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_active      high while the controller is in MERGE; low restarts the count
//   i_busy        OR-reduced PE busy
//   o_quiet_done  high in the cycle that completes MERGE_QUIET quiet cycles
module merge_quiet_counter #(
  parameter int MERGE_QUIET = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_busy,
  output logic o_quiet_done
);

  localparam int CW = $clog2(MERGE_QUIET + 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(MERGE_QUIET - 1);
  localparam logic [CW-1:0] QUIET_MAX  = CW'(MERGE_QUIET);

  logic [1:0]    r_blank;
  logic [CW-1:0] r_quiet;
  logic          w_blanking;

  assign w_blanking = (r_blank != 2'd2);

  // Blanking runs first; afterwards any busy cycle restarts the quiet run.
  always_ff @(posedge clk) begin
    if (reset || !i_active) begin
      r_blank <= 2'd0;
      r_quiet <= '0;
    end else if (w_blanking) begin
      r_blank <= r_blank + 2'd1;
    end else if (i_busy) begin
      r_quiet <= '0;
    end else if (r_quiet != QUIET_MAX) begin
      r_quiet <= r_quiet + CW'(1);
    end
  end

  // Fires on the cycle that would bring the run to MERGE_QUIET so the
  // controller can leave MERGE on the following edge.
  assign o_quiet_done = i_active && !w_blanking && !i_busy && (r_quiet == QUIET_LAST);

endmodule

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the Union-Find decoder array.
// Runs each decoding round: load every context, then grow/merge each context
// round-robin until all have converged (or timed out), then peel and hand
// each result to the host. The FSM state register is the stage broadcast.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_start_valid    host measurements for the current context are ready
//   o_start_ready    controller accepts those measurements this cycle
//   i_busy_any       OR of all PE busy flags
//   i_odd_any        OR of all PE odd flags
//   o_global_stage   registered stage broadcast
//   o_context_id     context currently live in the PE registers
//   o_result_valid   peeled result for o_context_id is on the PE outputs
//   i_result_ready   host consumed the result
//   o_timeout        sticky; some context reached MAX_GROW while still odd
//   o_grow_count     grow iterations of the current context (saturating)
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS = 2,
  parameter int MAX_GROW     = 31,
  parameter int GROW_CYCLES  = 2,
  parameter int MERGE_QUIET  = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_start_valid,
  output logic                                 o_start_ready,
  input  logic                                 i_busy_any,
  input  logic                                 i_odd_any,
  output logic [STAGE_WIDTH-1:0]               o_global_stage,
  output logic [ctxIdxWidth(NUM_CONTEXTS)-1:0] o_context_id,
  output logic                                 o_result_valid,
  input  logic                                 i_result_ready,
  output logic                                 o_timeout,
  output logic [7:0]                           o_grow_count
);

  localparam int                CTX_W     = ctxIdxWidth(NUM_CONTEXTS);
  localparam bit                MULTI_CTX = (NUM_CONTEXTS > 1);
  localparam logic [CTX_W-1:0]  LAST_CTX  = CTX_W'(NUM_CONTEXTS - 1);
  localparam int                GT_W      = $clog2(GROW_CYCLES + 1);
  localparam logic [GT_W-1:0]   GROW_LAST = GT_W'(GROW_CYCLES - 1);
  localparam logic [7:0]        MAX_GROW_SAT = (MAX_GROW > 255) ? 8'd255 : 8'(MAX_GROW);

  stage_e                  r_state, w_nextState;
  phase_e                  r_phase, w_nextPhase;
  logic [CTX_W-1:0]        r_ctx, w_nextCtx, w_pendingCtx, w_probe;
  logic [NUM_CONTEXTS-1:0] r_done, w_doneAfter, w_ctxMask;
  logic [7:0]              r_growArr [NUM_CONTEXTS];
  logic [GT_W-1:0]         r_growTimer;
  logic                    r_timeout;
  logic                    r_readyArm;
  logic                    w_startReady;
  logic                    w_markDone;
  logic                    w_setTimeout;
  logic                    w_quietDone;
  logic                    w_growEntry;
  logic [7:0]              w_curGrow;

  merge_quiet_counter #(
    .MERGE_QUIET(MERGE_QUIET)
  ) u_merge_quiet_counter (
    .clk         (clk),
    .reset       (reset),
    .i_active    (r_state == ST_MERGE),
    .i_busy      (i_busy_any),
    .o_quiet_done(w_quietDone)
  );

  // r_readyArm keeps start_ready low for the first cycle out of reset.
  assign w_startReady = (r_state == ST_IDLE) && (r_phase == PH_LOAD) && r_readyArm;
  assign w_curGrow    = r_growArr[r_ctx];
  assign w_growEntry  = (w_nextState == ST_GROW) && (r_state != ST_GROW);

  always_comb begin
    w_ctxMask        = '0;
    w_ctxMask[r_ctx] = 1'b1;
  end

  // Round-robin search for the nearest context after r_ctx that is not done.
  // Scanning from the farthest offset down leaves the nearest hit last.
  // NUM_CONTEXTS is a power of two, so index wrap is the natural overflow.
  always_comb begin
    w_pendingCtx = r_ctx;
    w_probe      = '0;
    for (int k = NUM_CONTEXTS; k >= 1; k--) begin
      w_probe = r_ctx + CTX_W'(k);
      if (!r_done[w_probe]) begin
        w_pendingCtx = w_probe;
      end
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextPhase  = r_phase;
    w_nextCtx    = r_ctx;
    w_markDone   = 1'b0;
    w_setTimeout = 1'b0;
    w_doneAfter  = r_done;

    case (r_state)
      ST_IDLE: begin
        if (i_start_valid && w_startReady) begin
          w_nextState = ST_MEAS_LOAD;
        end
      end

      ST_MEAS_LOAD: begin
        if (MULTI_CTX) begin
          w_nextState = ST_WRITE_TO_MEM;
        end else begin
          w_nextState = ST_GROW;
          w_nextPhase = PH_SOLVE;
          w_nextCtx   = '0;
        end
      end

      ST_WRITE_TO_MEM: begin
        case (r_phase)
          PH_LOAD: begin
            if (r_ctx == LAST_CTX) begin
              w_nextState = ST_GROW;
              w_nextPhase = PH_SOLVE;
              w_nextCtx   = '0;
            end else begin
              w_nextState = ST_IDLE;
              w_nextCtx   = r_ctx + CTX_W'(1);
            end
          end
          PH_SOLVE: begin
            w_nextState = ST_GROW;
            w_nextCtx   = w_pendingCtx;
          end
          default: begin
            if (r_ctx == LAST_CTX) begin
              w_nextState = ST_RESET_ROOTS;
            end else begin
              w_nextState = ST_PEELING;
              w_nextCtx   = r_ctx + CTX_W'(1);
            end
          end
        endcase
      end

      ST_GROW: begin
        if (r_growTimer == GROW_LAST) begin
          w_nextState = ST_MERGE;
        end
      end

      // A context that is still odd at MAX_GROW is retired with a timeout
      // so the remaining contexts can still be peeled.
      ST_MERGE: begin
        if (w_quietDone) begin
          if (!i_odd_any) begin
            w_markDone = 1'b1;
          end else if (w_curGrow >= MAX_GROW_SAT) begin
            w_markDone   = 1'b1;
            w_setTimeout = 1'b1;
          end
          w_doneAfter = w_markDone ? (r_done | w_ctxMask) : r_done;
          if (&w_doneAfter) begin
            w_nextState = ST_PEELING;
            w_nextPhase = PH_PEEL;
            w_nextCtx   = '0;
          end else if (MULTI_CTX) begin
            w_nextState = ST_WRITE_TO_MEM;
          end else begin
            w_nextState = ST_GROW;
          end
        end
      end

      ST_PEELING: begin
        w_nextState = ST_RESULT_VALID;
      end

      ST_RESULT_VALID: begin
        if (i_result_ready) begin
          w_nextState = MULTI_CTX ? ST_WRITE_TO_MEM : ST_RESET_ROOTS;
        end
      end

      ST_RESET_ROOTS: begin
        w_nextState = ST_IDLE;
        w_nextPhase = PH_LOAD;
        w_nextCtx   = '0;
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextPhase = PH_LOAD;
        w_nextCtx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_GROW)) begin
      r_growTimer <= '0;
    end else begin
      r_growTimer <= r_growTimer + GT_W'(1);
    end
  end

  // Grow counts live per context; the entry into GROW bumps the count of
  // the context that is about to become live.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_LOAD;
      r_ctx      <= '0;
      r_done     <= '0;
      r_timeout  <= 1'b0;
      r_readyArm <= 1'b0;
      for (int i = 0; i < NUM_CONTEXTS; i++) begin
        r_growArr[i] <= 8'd0;
      end
    end else begin
      r_state    <= w_nextState;
      r_phase    <= w_nextPhase;
      r_ctx      <= w_nextCtx;
      r_readyArm <= 1'b1;
      if (w_setTimeout) begin
        r_timeout <= 1'b1;
      end
      if (r_state == ST_RESET_ROOTS) begin
        r_done <= '0;
      end else if (w_markDone) begin
        r_done <= r_done | w_ctxMask;
      end
      if (r_state == ST_RESET_ROOTS) begin
        for (int i = 0; i < NUM_CONTEXTS; i++) begin
          r_growArr[i] <= 8'd0;
        end
      end else if (w_growEntry && (r_growArr[w_nextCtx] != 8'hFF)) begin
        r_growArr[w_nextCtx] <= r_growArr[w_nextCtx] + 8'd1;
      end
    end
  end

  assign o_global_stage = r_state;
  assign o_context_id   = r_ctx;
  assign o_start_ready  = w_startReady;
  assign o_result_valid = (r_state == ST_RESULT_VALID);
  assign o_timeout      = r_timeout;
  assign o_grow_count   = w_curGrow;

endmodule

// File: doc/decoder_stage_controller.md
# decoder_stage_controller

Global stage sequencer for the Union-Find decoder array. It drives `global_stage` to every `processing_unit` and runs each decoding round through its stages: load, then repeated grow/merge, then peel and result. It merges convergence using the OR-reduced `busy` and `odd` from the array, and rotates the PE context memories in round-robin order when `NUM_CONTEXTS > 1`. It sits directly upstream of the PE array, with the host-side measurement/result handshake on its other side.

## Interface
- `STAGE_WIDTH`, 3: stage bus width; comes from the shared parameters package.
- `NUM_CONTEXTS`, 2: number of contexts per PE; must be a power of two, ≥1.
- `MAX_GROW`, 31: grow iterations allowed per context before timeout.
- `GROW_CYCLES`, 2: cycles spent in STAGE_GROW per iteration; must be ≥1.
- `MERGE_QUIET`, 3: consecutive cycles with `busy_any=0` needed to end a merge; must be ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start_valid`  in  1  host has measurements for the current context on the PE measurement inputs.
- `start_ready`  out  1  controller will take those measurements this cycle.
- `busy_any`  in  1  OR of all PE `busy` (registered in the PE).
- `odd_any`  in  1  OR of all PE `odd`.
- `global_stage`  out  STAGE_WIDTH  stage broadcast to the array; registered.
- `context_id`  out  log2(NUM_CONTEXTS) (minimum 1)  context currently live in the PE registers.
- `result_valid`  out  1  peeled errors for `context_id` are on the PE `neighbor_is_error` outputs.
- `result_ready`  in  1  host has consumed the result.
- `timeout`  out  1  sticky; a context hit `MAX_GROW`.
- `grow_count`  out  8  grow iterations of the current context; saturates at 255.

## Operation
- Stage encodings are fixed in the shared package: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, RESULT_VALID=5, WRITE_TO_MEM=6, RESET_ROOTS=7.
- **LOAD phase**
  - The FSM sits in IDLE with `start_ready=1`.
  - On `start_valid && start_ready` it enters MEASUREMENT_LOADING for 1 cycle.
  - If `NUM_CONTEXTS>1`, a 1-cycle WRITE_TO_MEM follows and `context_id` increments.
  - The FSM returns to IDLE until all contexts are loaded.
  - After the last context it goes to GROW, with `context_id` wrapped to 0.
- **SOLVE loop, per context**
  - GROW lasts `GROW_CYCLES` cycles; `grow_count` increments on entry.
  - MERGE follows. It exits once `busy_any` has been 0 for `MERGE_QUIET` consecutive cycles. The quiet counter clears on any `busy_any=1` and restarts at each MERGE entry.
  - On merge exit, with `odd_any` sampled on the exit cycle:
    - `odd_any=1` and `grow_count<MAX_GROW`: the context is not done.
    - `odd_any=1` and `grow_count=MAX_GROW`: set `timeout` and mark the context done.
    - `odd_any=0`: set `done[context_id]`.
  - If `NUM_CONTEXTS>1`: go to WRITE_TO_MEM (1 cycle), advance `context_id` to the next context not yet done, then GROW. When all contexts are done, go to the PEEL phase instead.
  - If `NUM_CONTEXTS=1`: skip WRITE_TO_MEM; go to GROW, or to PEEL when done.
- **PEEL phase, per context in order 0..N-1**
  - PEELING lasts 1 cycle.
  - RESULT_VALID holds `result_valid=1` until `result_ready`.
  - Then WRITE_TO_MEM (skipped when N=1).
  - After the last context: RESET_ROOTS for 1 cycle, clear `done`, clear `grow_count`, `context_id=0`, go to IDLE.
- `grow_count` reloads from a per-context array on each context switch.
- The `done` bitmap has `NUM_CONTEXTS` bits.

## Timing
- Reset values:
  - `global_stage`=IDLE
  - `context_id`=0
  - `start_ready`=0 in the first cycle after reset, then 1
  - `result_valid`=0
  - `timeout`=0
  - `grow_count`=0
  - `done` array cleared
- `global_stage` is registered; the PEs see it one cycle later through their own `stage` register. The controller therefore ignores `busy_any` for the first 2 cycles of MERGE; this is what makes `MERGE_QUIET≥2` required.
- Minimum MERGE length is 2+`MERGE_QUIET` cycles.
- `start_ready` is 1 only in IDLE during the LOAD phase.
- `result_valid` is 1 exactly while `global_stage`=RESULT_VALID. It deasserts the cycle after the handshake.
- Reset asserted mid-round returns everything to reset values on the next edge. No partial state survives.
- `start_valid` arriving outside LOAD is ignored; there is no acceptance.

## Structure
- The stage localparams, `STAGE_WIDTH` and the context-index width function belong in the shared parameters package.
- One sub-module: `merge_quiet_counter` (saturating quiet-cycle counter with clear and a 2-cycle blanking window).
- The main FSM and the per-context `done`/`grow_count` arrays stay in the top module.

## Test plan
- N=1; `odd_any` stays 0 at the first merge:
  - required stage sequence: IDLE→1→2,2→3 (5 cycles)→4→5.
  - With `result_ready` held 1: 5 lasts 1 cycle, then 7→0.
  - `grow_count`=1.
- N=2; both contexts need 3 grows:
  - required order: 1,6,1,6, then (2,2,3…,6) alternating context 0/1 for 6 rounds, then 4,5,6,4,5,6,7.
- `busy_any` pulses at merge cycles 4 and 7: MERGE ends exactly 3 quiet cycles after cycle 7.
- `odd_any` stays 1 with `MAX_GROW=3`:
  - `timeout` rises at the third merge exit.
  - The context is marked done; PEEL still runs.
- `result_ready` held 0 for 10 cycles: `result_valid` stays 1 and `global_stage` holds at 5.
- Reset asserted during MERGE: the next cycle shows `global_stage`=0, `context_id`=0, `timeout`=0, `result_valid`=0, and `start_ready`=0 that cycle, then 1.
